// File: rtl/cond_logic_if.sv
// Decoder-to-condition-stage bundle for cond_logic_unit: control requests in, gated enables, flags and statistics out.
interface cond_logic_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             Stall;
  logic             CondLatch;
  logic             InstrValid;
  logic             StatClr;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic [3:0]       Flags;
  logic             CondEx;
  logic             CondUndef;
  logic [CNT_W-1:0] ExecCount;
  logic [CNT_W-1:0] SquashCount;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall, CondLatch, InstrValid, StatClr,
    input  PCSrc, RegWrite, MemWrite, Flags, CondEx, CondUndef, ExecCount, SquashCount
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall, CondLatch, InstrValid, StatClr,
    output PCSrc, RegWrite, MemWrite, Flags, CondEx, CondUndef, ExecCount, SquashCount
  );
endinterface

// File: rtl/cond_logic_unit.sv
// NZCV flag register, condition evaluation and write-enable gating.
// Optional execute/squash statistics counters enabled by defining COND_STATS_EN.
module cond_logic_unit #(
  parameter int unsigned REG_COND    = 0,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000,
  parameter int unsigned CNT_W       = 16
) (
  input logic        clk,
  input logic        reset,
  cond_logic_if.slave bus
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_r_q, cond_ex_r_d;
  logic       cond_ex_l;
  logic       cond_ex;
  logic [1:0] flag_write;
  logic       n_f, z_f, c_f, v_f;

  always_comb begin
    {n_f, z_f, c_f, v_f} = flags_q;
    cond_ex_l = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex_l = z_f;
      4'b0001: cond_ex_l = ~z_f;
      4'b0010: cond_ex_l = c_f;
      4'b0011: cond_ex_l = ~c_f;
      4'b0100: cond_ex_l = n_f;
      4'b0101: cond_ex_l = ~n_f;
      4'b0110: cond_ex_l = v_f;
      4'b0111: cond_ex_l = ~v_f;
      4'b1000: cond_ex_l = c_f & ~z_f;
      4'b1001: cond_ex_l = ~c_f | z_f;
      4'b1010: cond_ex_l = (n_f == v_f);
      4'b1011: cond_ex_l = (n_f != v_f);
      4'b1100: cond_ex_l = ~z_f & (n_f == v_f);
      4'b1101: cond_ex_l = z_f | (n_f != v_f);
      4'b1110: cond_ex_l = 1'b1;
      default: cond_ex_l = 1'b0;
    endcase
  end

  always_comb begin
    cond_ex    = (REG_COND != 0) ? cond_ex_r_q : cond_ex_l;
    flag_write = bus.FlagW & {2{cond_ex}} & {2{~bus.Stall}};

    flags_d = flags_q;
    if (flag_write[1]) flags_d[3:2] = bus.ALUFlags[3:2];
    if (flag_write[0]) flags_d[1:0] = bus.ALUFlags[1:0];

    // Stall takes priority over a same-cycle latch request.
    cond_ex_r_d = (bus.CondLatch && !bus.Stall) ? cond_ex_l : cond_ex_r_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q     <= RESET_FLAGS;
      cond_ex_r_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      cond_ex_r_q <= cond_ex_r_d;
    end
  end

  always_comb begin
    bus.PCSrc     = bus.PCS & cond_ex;
    bus.RegWrite  = bus.RegW & ~bus.NoWrite & cond_ex;
    bus.MemWrite  = bus.MemW & cond_ex;
    bus.Flags     = flags_q;
    bus.CondEx    = cond_ex;
    bus.CondUndef = (bus.Cond == 4'b1111);
  end

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  always_comb begin
    exec_cnt_d   = exec_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (bus.StatClr) begin
      exec_cnt_d   = '0;
      squash_cnt_d = '0;
    end else if (bus.InstrValid && !bus.Stall) begin
      if (cond_ex) begin
        if (exec_cnt_q != '1) exec_cnt_d = exec_cnt_q + CNT_W'(1);
      end else begin
        if (squash_cnt_q != '1) squash_cnt_d = squash_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_cnt_q   <= '0;
      squash_cnt_q <= '0;
    end else begin
      exec_cnt_q   <= exec_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  always_comb begin
    bus.ExecCount   = exec_cnt_q;
    bus.SquashCount = squash_cnt_q;
  end
`else
  logic unused_stats;

  always_comb begin
    bus.ExecCount   = '0;
    bus.SquashCount = '0;
    unused_stats    = bus.InstrValid ^ bus.StatClr;
  end
`endif

endmodule

// File: tb/tb_cond_logic_unit.sv
// Bench for cond_logic_unit: a live-condition and a registered-condition instance checked against a behavioural model.
module tb_cond_logic_unit;

  localparam int unsigned CW  = 2;
  localparam int          SAT = (1 << CW) - 1;

  logic clk;
  logic reset;

  cond_logic_if #(.CNT_W(CW)) if0 ();
  cond_logic_if #(.CNT_W(CW)) if1 ();

  cond_logic_unit #(.REG_COND(0), .RESET_FLAGS(4'b0100), .CNT_W(CW)) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );
  cond_logic_unit #(.REG_COND(1), .RESET_FLAGS(4'b0100), .CNT_W(CW)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] t_cond, t_alu;
  logic [1:0] t_flagw;
  logic       t_pcs, t_regw, t_memw, t_nowr, t_stall, t_latch, t_valid, t_clr;

  logic [3:0] m_flags [2];
  logic       m_cexr  [2];
  int         m_exec  [2];
  int         m_sq    [2];

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  // Conditions come in complementary pairs: even code tests the base predicate, odd code its inverse.
  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    if (c == 4'b1110) return 1'b1;
    if (c == 4'b1111) return 1'b0;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf && !z;
      3'd5:    base = (n == v);
      default: base = !z && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic model_ex(input int i);
    return (i == 1) ? m_cexr[1] : cond_true(t_cond, m_flags[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_flags[i] = 4'b0100;
      m_cexr[i]  = 1'b0;
      m_exec[i]  = 0;
      m_sq[i]    = 0;
    end
  endtask

  task automatic model_edge();
    logic cexl, cex;
    for (int i = 0; i < 2; i++) begin
      cexl = cond_true(t_cond, m_flags[i]);
      cex  = model_ex(i);
`ifdef COND_STATS_EN
      if (t_clr) begin
        m_exec[i] = 0;
        m_sq[i]   = 0;
      end else if (t_valid && !t_stall) begin
        if (cex) m_exec[i] = (m_exec[i] == SAT) ? SAT : m_exec[i] + 1;
        else     m_sq[i]   = (m_sq[i] == SAT) ? SAT : m_sq[i] + 1;
      end
`endif
      if (!t_stall) begin
        if (cex && t_flagw[1]) m_flags[i][3:2] = t_alu[3:2];
        if (cex && t_flagw[0]) m_flags[i][1:0] = t_alu[1:0];
        if (t_latch) m_cexr[i] = cexl;
      end
    end
  endtask

  task automatic apply();
    if0.Cond = t_cond;   if1.Cond = t_cond;
    if0.ALUFlags = t_alu; if1.ALUFlags = t_alu;
    if0.FlagW = t_flagw; if1.FlagW = t_flagw;
    if0.PCS = t_pcs;     if1.PCS = t_pcs;
    if0.RegW = t_regw;   if1.RegW = t_regw;
    if0.MemW = t_memw;   if1.MemW = t_memw;
    if0.NoWrite = t_nowr; if1.NoWrite = t_nowr;
    if0.Stall = t_stall; if1.Stall = t_stall;
    if0.CondLatch = t_latch; if1.CondLatch = t_latch;
    if0.InstrValid = t_valid; if1.InstrValid = t_valid;
    if0.StatClr = t_clr; if1.StatClr = t_clr;
  endtask

  task automatic check_comb(input int i, input logic ce, input logic pc, input logic rw,
                            input logic mw, input logic ud);
    logic e;
    e = model_ex(i);
    chk("condex", i, ce, e);
    chk("pcsrc", i, pc, t_pcs && e);
    chk("regwrite", i, rw, t_regw && !t_nowr && e);
    chk("memwrite", i, mw, t_memw && e);
    chk("condundef", i, ud, t_cond == 4'b1111);
  endtask

  task automatic check_state(input int i, input logic [3:0] fl, input logic [CW-1:0] ec,
                             input logic [CW-1:0] sc);
    chk("flags", i, fl, m_flags[i]);
    chk("execcount", i, ec, m_exec[i]);
    chk("squashcount", i, sc, m_sq[i]);
  endtask

  task automatic tick();
    apply();
    #1;
    check_comb(0, if0.CondEx, if0.PCSrc, if0.RegWrite, if0.MemWrite, if0.CondUndef);
    check_comb(1, if1.CondEx, if1.PCSrc, if1.RegWrite, if1.MemWrite, if1.CondUndef);
    @(posedge clk);
    model_edge();
    #1;
    check_state(0, if0.Flags, if0.ExecCount, if0.SquashCount);
    check_state(1, if1.Flags, if1.ExecCount, if1.SquashCount);
  endtask

  task automatic set(input logic [3:0] c, input logic [3:0] a, input logic [1:0] fw);
    t_cond = c; t_alu = a; t_flagw = fw;
  endtask

  initial begin
    t_cond = '0; t_alu = '0; t_flagw = '0;
    t_pcs = 0; t_regw = 0; t_memw = 0; t_nowr = 0;
    t_stall = 0; t_latch = 0; t_valid = 0; t_clr = 0;
    apply();
    reset = 1'b1;
    model_reset();
    #2;
    chk("reset_flags", 0, if0.Flags, 4'b0100);
    chk("reset_flags", 1, if1.Flags, 4'b0100);
    chk("reset_condexr", 1, if1.CondEx, 1'b0);
    #10 reset = 1'b0;

    set(4'b0000, 4'b0000, 2'b00); tick();
    chk("eq_reset", 0, if0.CondEx, 1'b1);
    set(4'b0001, 4'b0000, 2'b00); tick();
    chk("ne_reset", 0, if0.CondEx, 1'b0);

    // registered condition: latch EQ true, then clear Z; CondEx must hold until next latch
    set(4'b0000, 4'b0000, 2'b00); t_latch = 1; tick();
    t_latch = 0; set(4'b1110, 4'b0000, 2'b11); tick();
    set(4'b0000, 4'b0000, 2'b00); tick();
    chk("regcond_hold", 1, if1.CondEx, 1'b1);
    chk("live_eq_now_false", 0, if0.CondEx, 1'b0);
    t_latch = 1; t_stall = 1; tick();
    chk("latch_stalled", 1, if1.CondEx, 1'b1);
    t_stall = 0; tick();
    chk("latch_relatch", 1, if1.CondEx, 1'b0);
    t_latch = 0;

    set(4'b1110, 4'b1001, 2'b11); tick();
    chk("flags_1001", 0, if0.Flags, 4'b1001);
    set(4'b1011, 4'b0000, 2'b00); tick(); chk("lt", 0, if0.CondEx, 1'b0);
    set(4'b1010, 4'b0000, 2'b00); tick(); chk("ge", 0, if0.CondEx, 1'b1);
    set(4'b0100, 4'b0000, 2'b00); tick(); chk("mi", 0, if0.CondEx, 1'b1);

    set(4'b1110, 4'b0010, 2'b11); tick();
    set(4'b1110, 4'b0101, 2'b10); tick();
    chk("flags_partial", 0, if0.Flags, 4'b0110);
    set(4'b1000, 4'b0000, 2'b00); tick(); chk("hi", 0, if0.CondEx, 1'b0);
    set(4'b1001, 4'b0000, 2'b00); tick(); chk("ls", 0, if0.CondEx, 1'b1);

    set(4'b1110, 4'b0010, 2'b11); tick();
    t_pcs = 1; t_regw = 1; t_memw = 1;
    set(4'b0000, 4'b1111, 2'b11); tick();
    chk("squash_pcsrc", 0, if0.PCSrc, 1'b0);
    chk("squash_regwrite", 0, if0.RegWrite, 1'b0);
    chk("squash_memwrite", 0, if0.MemWrite, 1'b0);
    chk("squash_flags", 0, if0.Flags, 4'b0010);
    t_nowr = 1; set(4'b1110, 4'b0000, 2'b00); tick();
    chk("nowrite_regwrite", 0, if0.RegWrite, 1'b0);
    chk("al_pcsrc", 0, if0.PCSrc, 1'b1);
    t_nowr = 0; t_pcs = 0; t_regw = 0; t_memw = 0;

`ifdef COND_STATS_EN
    t_clr = 1; tick();
    t_clr = 0; t_valid = 1;
    for (int k = 0; k < 4; k++) tick();
    chk("exec_saturated", 0, if0.ExecCount, 2'd3);
    t_clr = 1; tick();
    chk("clr_exec", 0, if0.ExecCount, 2'd0);
    chk("clr_squash", 0, if0.SquashCount, 2'd0);
    t_clr = 0; set(4'b1111, 4'b0000, 2'b00); tick();
    chk("undef", 0, if0.CondUndef, 1'b1);
    chk("undef_squash", 0, if0.SquashCount, 2'd1);
    t_valid = 0;
`endif

    for (int k = 0; k < 400; k++) begin
      t_cond  = 4'($urandom_range(15));
      t_alu   = 4'($urandom_range(15));
      t_flagw = 2'($urandom_range(3));
      t_pcs   = 1'($urandom_range(1));
      t_regw  = 1'($urandom_range(1));
      t_memw  = 1'($urandom_range(1));
      t_nowr  = 1'($urandom_range(1));
      t_stall = ($urandom_range(3) == 0);
      t_latch = 1'($urandom_range(1));
      t_valid = 1'($urandom_range(1));
      t_clr   = ($urandom_range(15) == 0);
      tick();
    end

    // asynchronous reset in the middle of a cycle
    #3 reset = 1'b1;
    model_reset();
    #1;
    chk("midreset_flags", 0, if0.Flags, 4'b0100);
    chk("midreset_flags", 1, if1.Flags, 4'b0100);
    chk("midreset_condexr", 1, if1.CondEx, 1'b0);
    chk("midreset_exec", 0, if0.ExecCount, 0);
    chk("midreset_squash", 0, if0.SquashCount, 0);
    #1 reset = 1'b0;
    t_stall = 0; t_latch = 0; t_clr = 0; t_valid = 0;
    set(4'b0000, 4'b0000, 2'b00); tick();
    chk("eq_after_midreset", 0, if0.CondEx, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
